branch_resolve_bht: RTL

ID-stage branch resolution unit with an integrated branch history table (BHT) of 2-bit saturating counters. The IF stage reads a prediction by PC. The ID stage evaluates the MIPS branch condition on forwarded operands, flags a mispredict against the prediction carried down the pipe, and trains the table. Operand width and table depth are parametrised, and resolution statistics are counted for performance debug.

---
 rtl/branch_resolve_bht.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// branch_resolve_bht
//
// ID-stage branch resolution with an integrated branch history table of 2-bit
// saturating counters. IF reads a prediction by PC. ID evaluates the MIPS
// branch condition on forwarded operands, flags a mispredict against the
// prediction carried down the pipe, and trains the table. Resolution counts
// are kept for performance debug.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   stall          ID held; suppresses table and statistics updates
//   if_pc          PC of the instruction in IF
//   if_pred_taken  MSB of the counter indexed by if_pc (combinational)
//   id_valid       ID holds a live instruction
//   id_pc          PC of the instruction in ID
//   id_op, id_rt   opcode and rt (REGIMM subcode) fields
//   id_a, id_b     forwarded rs / rt operands
//   id_pred_taken  prediction made for this instruction in IF
//   id_is_branch   live, recognised conditional branch
//   id_taken       branch condition true (0 when not a branch)
//   id_mispredict  resolved direction differs from the carried prediction
//   branch_cnt     resolved branches since reset (saturating)
//   miss_cnt       mispredicts since reset (saturating)
// -----------------------------------------------------------------------------
module branch_resolve_bht #(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_LSB   = 2,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [31:0]       if_pc,
    output logic              if_pred_taken,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [5:0]        id_op,
    input  logic [4:0]        id_rt,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic              id_pred_taken,
    output logic              id_is_branch,
    output logic              id_taken,
    output logic              id_mispredict,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] id_idx;
    logic             op_is_br;
    logic             cond;
    logic             a_neg;
    logic             a_zero;
    logic             update;

    // PC bits outside the index field are intentionally ignored (aliasing).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc, id_pc};

    assign if_idx = if_pc[IDX_LSB +: IDX_W];
    assign id_idx = id_pc[IDX_LSB +: IDX_W];

    // Read is taken from the registered table only, so an update to the same
    // entry in this cycle is not visible until the next one.
    assign if_pred_taken = bht[if_idx][1];

    assign a_neg  = id_a[DATA_W-1];
    assign a_zero = (id_a == '0);

    always_comb begin
        op_is_br = 1'b0;
        cond     = 1'b0;
        case (id_op)
            OP_BEQ: begin
                op_is_br = 1'b1;
                cond     = (id_a == id_b);
            end
            OP_BNE: begin
                op_is_br = 1'b1;
                cond     = (id_a != id_b);
            end
            OP_BLEZ: begin
                op_is_br = 1'b1;
                cond     = a_neg | a_zero;
            end
            OP_BGTZ: begin
                op_is_br = 1'b1;
                cond     = !a_neg && !a_zero;
            end
            OP_REGIMM: begin
                case (id_rt)
                    RT_BLTZ, RT_BLTZAL: begin
                        op_is_br = 1'b1;
                        cond     = a_neg;
                    end
                    RT_BGEZ, RT_BGEZAL: begin
                        op_is_br = 1'b1;
                        cond     = !a_neg;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign id_is_branch  = id_valid & op_is_br;
    assign id_taken      = id_is_branch & cond;
    assign id_mispredict = id_is_branch & (id_taken ^ id_pred_taken);

    // A stalled branch stays in ID; it is trained and counted only on the
    // cycle it is released, which gives exactly-once behaviour.
    assign update = id_is_branch & !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (update) begin
            if (id_taken) begin
                if (bht[id_idx] != 2'b11) bht[id_idx] <= bht[id_idx] + 2'd1;
            end else begin
                if (bht[id_idx] != 2'b00) bht[id_idx] <= bht[id_idx] - 2'd1;
            end
            if (branch_cnt != '1) branch_cnt <= branch_cnt + STAT_ONE;
            if (id_mispredict && (miss_cnt != '1)) miss_cnt <= miss_cnt + STAT_ONE;
        end
    end

endmodule
